// File: rtl/conv_loop_ctrl_par_pkg.sv
// Shared types and helpers for the convolution loop controller.
package conv_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, MAC, DONE} fsm_state_e;
  typedef enum logic [1:0] {KERN_1X1, KERN_3X3, KERN_5X5, KERN_BAD} kernel_mode_e;
  typedef enum logic [1:0] {STRIDE_1, STRIDE_2, STRIDE_4, STRIDE_BAD} stride_mode_e;

  // K = 2*mode+1
  function automatic logic [2:0] kernel_size(input kernel_mode_e m);
    return {2'(m), 1'b1};
  endfunction

  function automatic logic [2:0] stride_val(input stride_mode_e m);
    return 3'b001 << 2'(m);
  endfunction

  // Counter width that never collapses to zero bits for a bound of 1.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_loop_ctrl_par_if.sv
// Operand handshake, MAC control, psum memory and output tagging bundle.
interface conv_loop_ctrl_par_if #(
  parameter int MEM_AW = 4,
  parameter int XW     = 10,
  parameter int YW     = 10
);
  logic              a_valid, a_ready, write_a;
  logic              b_valid, b_ready, write_b;
  logic              mac_valid, mac_acc_int, mac_acc_zero;
  logic              mem_re, mem_we;
  logic [MEM_AW-1:0] mem_raddr, mem_waddr;
  logic              out_valid;
  logic [XW-1:0]     out_x;
  logic [YW-1:0]     out_y;
  logic [MEM_AW-1:0] out_grp;

  modport master (
    input  a_valid, b_valid,
    output a_ready, b_ready, write_a, write_b,
           mac_valid, mac_acc_int, mac_acc_zero,
           mem_re, mem_raddr, mem_we, mem_waddr,
           out_valid, out_x, out_y, out_grp
  );

  modport slave (
    output a_valid, b_valid,
    input  a_ready, b_ready, write_a, write_b,
           mac_valid, mac_acc_int, mac_acc_zero,
           mem_re, mem_raddr, mem_we, mem_waddr,
           out_valid, out_x, out_y, out_grp
  );
endinterface

// File: rtl/conv_loop_ctrl_par_loop_counter.sv
// One loop level: advances by step on we, wraps to 0 when cnt+step reaches bound.
module loop_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic             clr,
  input  logic             we,
  input  logic [WIDTH:0]   step,
  input  logic [WIDTH:0]   bound,
  output logic [WIDTH-1:0] cnt,
  output logic             last
);
  logic [WIDTH+1:0] sum;

  assign sum  = {2'b00, cnt} + {1'b0, step};
  assign last = (sum >= {1'b0, bound});

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in)  cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (we)     cnt <= last ? '0 : sum[WIDTH-1:0];
  end
endmodule

// File: rtl/conv_loop_ctrl_par.sv
// Convolution loop controller for PAR_OUT-wide MAC array (x,y,ch_in,grp,k_v,k_h).
// Optional stall counter enabled by CONV_CTRL_PERF_CNT_EN.
module conv_loop_ctrl_par
  import conv_ctrl_pkg::*;
#(
  parameter int MAX_FM_W = 1024,
  parameter int MAX_FM_H = 1024,
  parameter int IN_CH    = 64,
  parameter int OUT_CH   = 64,
  parameter int PAR_OUT  = 4,
  parameter int MEM_AW   = cw(OUT_CH / PAR_OUT)
) (
  input  logic                    clk,
  input  logic                    arst_n_in,
  input  logic                    start,
  input  logic [1:0]              cfg_kernel,
  input  logic [1:0]              cfg_stride,
  input  logic [cw(MAX_FM_W):0]   cfg_w,
  input  logic [cw(MAX_FM_H):0]   cfg_h,
  output logic                    running,
  output logic                    done,
  output logic                    cfg_error,
  output logic [31:0]             stall_cycles,
  conv_loop_ctrl_par_if.master    bus
);
  localparam int G   = OUT_CH / PAR_OUT;
  localparam int XW  = cw(MAX_FM_W);
  localparam int YW  = cw(MAX_FM_H);
  localparam int CIW = cw(IN_CH);
  localparam int KW  = 3;

  fsm_state_e   state, state_n;
  kernel_mode_e kern_q;
  stride_mode_e strd_q;
  logic [XW:0]  w_q;
  logic [YW:0]  h_q;

  logic illegal, accept, mac;
  logic a_have, b_have, a_have_n, b_have_n, a_rdy, b_rdy;

  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [CIW-1:0]    ci;
  logic [MEM_AW-1:0] grp;
  logic [KW-1:0]     kv, kh;
  logic l_x, l_y, l_ci, l_g, l_kv, l_kh;
  logic we_x, we_y, we_ci, we_g, we_kv;
  logic tap0, last_tap, last_overall, wb_fire;

  logic              wb_vld, out_q;
  logic [MEM_AW-1:0] wb_grp;
  logic [XW-1:0]     ox;
  logic [YW-1:0]     oy;

  assign illegal = (cfg_kernel == 2'd3) || (cfg_stride == 2'd3) || (cfg_w == '0) || (cfg_h == '0);
  assign accept  = (state == IDLE) && start && !illegal;
  assign mac     = (state == MAC);

  // Each level advances only when every inner level wraps in this MAC.
  assign we_kv = mac & l_kh;
  assign we_g  = we_kv & l_kv;
  assign we_ci = we_g & l_g;
  assign we_y  = we_ci & l_ci;
  assign we_x  = we_y & l_y;

  loop_counter #(.WIDTH(XW)) u_x (
    .clk, .arst_n_in, .clr(accept), .we(we_x),
    .step((XW+1)'(stride_val(strd_q))), .bound(w_q), .cnt(x), .last(l_x));
  loop_counter #(.WIDTH(YW)) u_y (
    .clk, .arst_n_in, .clr(accept), .we(we_y),
    .step((YW+1)'(stride_val(strd_q))), .bound(h_q), .cnt(y), .last(l_y));
  loop_counter #(.WIDTH(CIW)) u_ci (
    .clk, .arst_n_in, .clr(accept), .we(we_ci),
    .step((CIW+1)'(1)), .bound((CIW+1)'(IN_CH)), .cnt(ci), .last(l_ci));
  loop_counter #(.WIDTH(MEM_AW)) u_grp (
    .clk, .arst_n_in, .clr(accept), .we(we_g),
    .step((MEM_AW+1)'(1)), .bound((MEM_AW+1)'(G)), .cnt(grp), .last(l_g));
  loop_counter #(.WIDTH(KW)) u_kv (
    .clk, .arst_n_in, .clr(accept), .we(we_kv),
    .step((KW+1)'(1)), .bound({1'b0, kernel_size(kern_q)}), .cnt(kv), .last(l_kv));
  loop_counter #(.WIDTH(KW)) u_kh (
    .clk, .arst_n_in, .clr(accept), .we(mac),
    .step((KW+1)'(1)), .bound({1'b0, kernel_size(kern_q)}), .cnt(kh), .last(l_kh));

  assign tap0         = (kv == '0) && (kh == '0);
  assign last_tap     = l_kv & l_kh;
  assign last_overall = last_tap & l_g & l_ci & l_y & l_x;
  assign wb_fire      = mac & last_tap;

  assign a_have_n = a_have | (bus.a_valid & a_rdy);
  assign b_have_n = b_have | (bus.b_valid & b_rdy);

  always_comb begin
    state_n = state;
    a_rdy   = 1'b0;
    b_rdy   = 1'b0;
    case (state)
      IDLE:  if (accept) state_n = FETCH;
      FETCH: begin
        a_rdy = !a_have;
        b_rdy = !b_have;
        if (a_have_n && b_have_n) state_n = MAC;
      end
      MAC:   state_n = last_overall ? DONE : FETCH;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state     <= IDLE;
      a_have    <= 1'b0;
      b_have    <= 1'b0;
      cfg_error <= 1'b0;
      kern_q    <= KERN_1X1;
      strd_q    <= STRIDE_1;
      w_q       <= '0;
      h_q       <= '0;
    end else begin
      state     <= state_n;
      a_have    <= mac ? 1'b0 : a_have_n;
      b_have    <= mac ? 1'b0 : b_have_n;
      cfg_error <= (state == IDLE) && start && illegal;
      if ((state == IDLE) && start) begin
        kern_q <= kernel_mode_e'(cfg_kernel);
        strd_q <= stride_mode_e'(cfg_stride);
        w_q    <= cfg_w;
        h_q    <= cfg_h;
      end
    end
  end

  // Write-back / output tag stage, one cycle behind the last-tap MAC.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wb_vld <= 1'b0;
      out_q  <= 1'b0;
      wb_grp <= '0;
      ox     <= '0;
      oy     <= '0;
    end else begin
      wb_vld <= wb_fire;
      out_q  <= wb_fire && (ci == CIW'(IN_CH - 1));
      if (wb_fire) begin
        wb_grp <= grp;
        ox     <= x;
        oy     <= y;
      end
    end
  end

`ifdef CONV_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in)
      stall_cycles <= '0;
    else if (accept)
      stall_cycles <= '0;
    else if ((state == FETCH) && !(a_have_n && b_have_n) && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 32'd1;
  end
`else
  assign stall_cycles = '0;
`endif

  assign running          = (state != IDLE);
  assign done             = (state == DONE);
  assign bus.a_ready      = a_rdy;
  assign bus.b_ready      = b_rdy;
  assign bus.write_a      = bus.a_valid & a_rdy;
  assign bus.write_b      = bus.b_valid & b_rdy;
  assign bus.mac_valid    = mac;
  assign bus.mac_acc_int  = mac & !tap0;
  assign bus.mac_acc_zero = mac & tap0 & (ci == '0);
  assign bus.mem_re       = mac & tap0;
  assign bus.mem_raddr    = mac ? grp : '0;
  assign bus.mem_we       = wb_vld;
  assign bus.mem_waddr    = wb_grp;
  assign bus.out_valid    = out_q;
  assign bus.out_x        = ox;
  assign bus.out_y        = oy;
  assign bus.out_grp      = wb_grp;

endmodule

// File: tb/tb_conv_loop_ctrl_par.sv
// Directed bench for conv_loop_ctrl_par (IN_CH=2, OUT_CH=8, PAR_OUT=4, max map 8x8).
module tb_conv_loop_ctrl_par;
  localparam int IN_CH = 2;
  localparam int G     = 2;

`ifdef CONV_CTRL_PERF_CNT_EN
  localparam logic [31:0] HS_STALLS = 32'd3;
`else
  localparam logic [31:0] HS_STALLS = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        arst_n_in, start;
  logic [1:0]  cfg_kernel, cfg_stride;
  logic [3:0]  cfg_w, cfg_h;
  logic        running, done, cfg_error;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  conv_loop_ctrl_par_if #(.MEM_AW(1), .XW(3), .YW(3)) bus ();

  conv_loop_ctrl_par #(
    .MAX_FM_W(8), .MAX_FM_H(8), .IN_CH(IN_CH), .OUT_CH(8), .PAR_OUT(4)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start),
    .cfg_kernel(cfg_kernel), .cfg_stride(cfg_stride), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .running(running), .done(done), .cfg_error(cfg_error),
    .stall_cycles(stall_cycles), .bus(bus)
  );

  int vectors = 0;
  int fails   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference loop model and event counters, restarted at each start.
  int mk, ms, mw, mh, mx, my, mci, mg, mkv, mkh;
  int macs, outs, dones, wes, zeros, mon_err;
  logic [7:0] xs, ys;
  logic       pend_we, pend_out;
  logic [0:0] pg;
  logic [2:0] px, py;

  always @(negedge clk) begin : mon
    int e, nkh, nkv, ng, nci, ny, nx;
    bit t0;
    e = 0;
    if (!arst_n_in) begin
      pend_we <= 1'b0; pend_out <= 1'b0;
      mx <= 0; my <= 0; mci <= 0; mg <= 0; mkv <= 0; mkh <= 0;
    end else begin
      if (bus.mem_we !== pend_we) e++;
      else if (pend_we && bus.mem_waddr !== pg) e++;
      if (bus.out_valid !== pend_out) e++;
      else if (pend_out && (bus.out_x !== px || bus.out_y !== py || bus.out_grp !== pg)) e++;
      if (bus.out_valid === 1'b1) begin
        outs <= outs + 1; xs[bus.out_x] <= 1'b1; ys[bus.out_y] <= 1'b1;
      end
      if (bus.mem_we === 1'b1) wes <= wes + 1;
      if (done === 1'b1) dones <= dones + 1;
      pend_we <= 1'b0; pend_out <= 1'b0;
      if (bus.mac_valid === 1'b1) begin
        t0 = (mkv == 0 && mkh == 0);
        if (bus.mem_re !== t0 || bus.mem_raddr !== 1'(mg) || bus.mac_acc_int !== !t0 ||
            bus.mac_acc_zero !== (t0 && mci == 0)) e++;
        if (bus.mac_acc_zero === 1'b1) zeros <= zeros + 1;
        macs <= macs + 1;
        if (mkv == mk - 1 && mkh == mk - 1) begin
          pend_we <= 1'b1; pg <= 1'(mg); pend_out <= (mci == IN_CH - 1);
          px <= 3'(mx); py <= 3'(my);
        end
        nkh = mkh + 1; nkv = mkv; ng = mg; nci = mci; ny = my; nx = mx;
        if (nkh == mk) begin
          nkh = 0; nkv++;
          if (nkv == mk) begin
            nkv = 0; ng++;
            if (ng == G) begin
              ng = 0; nci++;
              if (nci == IN_CH) begin
                nci = 0; ny += ms;
                if (ny >= mh) begin
                  ny = 0; nx += ms;
                  if (nx >= mw) nx = 0;
                end
              end
            end
          end
        end
        mkh <= nkh; mkv <= nkv; mg <= ng; mci <= nci; my <= ny; mx <= nx;
      end
      mon_err <= mon_err + e;
      if (start === 1'b1 && running === 1'b0) begin
        mk <= 2 * int'(cfg_kernel) + 1; ms <= 1 << cfg_stride; mw <= int'(cfg_w); mh <= int'(cfg_h);
        mx <= 0; my <= 0; mci <= 0; mg <= 0; mkv <= 0; mkh <= 0;
        macs <= 0; outs <= 0; dones <= 0; wes <= 0; zeros <= 0; mon_err <= 0;
        xs <= '0; ys <= '0;
      end
    end
  end

  function automatic logic [63:0] all_outs();
    return 64'({running, done, cfg_error, bus.a_ready, bus.b_ready, bus.write_a, bus.write_b,
                bus.mac_valid, bus.mac_acc_int, bus.mac_acc_zero, bus.mem_re, bus.mem_raddr,
                bus.mem_we, bus.mem_waddr, bus.out_valid, bus.out_x, bus.out_y, bus.out_grp,
                stall_cycles});
  endfunction

  task automatic run(input logic [1:0] k, input logic [1:0] s, input logic [3:0] w,
                     input logic [3:0] h, input int budget, output bit ok);
    @(posedge clk) #1;
    cfg_kernel = k; cfg_stride = s; cfg_w = w; cfg_h = h;
    bus.a_valid = 1'b1; bus.b_valid = 1'b1; start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin : main
    bit ok;
    int n;
    arst_n_in = 1'b0; start = 1'b0;
    cfg_kernel = 2'd0; cfg_stride = 2'd0; cfg_w = 4'd0; cfg_h = 4'd0;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_outs(), 64'd0);
    @(posedge clk) #1;
    arst_n_in = 1'b1;

    // 1x1, stride 1, 2x2 map, operands always valid
    run(2'd0, 2'd0, 4'd2, 4'd2, 200, ok);
    chk("k1_done_seen", 64'(ok), 64'd1);
    chk("k1_macs", 64'(macs), 64'd16);
    chk("k1_outs", 64'(outs), 64'd8);
    chk("k1_dones", 64'(dones), 64'd1);
    chk("k1_mem_we", 64'(wes), 64'd16);
    chk("k1_acc_zero", 64'(zeros), 64'd8);
    chk("k1_stalls", 64'(stall_cycles), 64'd0);
    chk("k1_model", 64'(mon_err), 64'd0);
    chk("k1_running_after", 64'(running), 64'd0);

    // 3x3, stride 2, 5x5 map: 9 output points, 36 MACs each
    run(2'd1, 2'd1, 4'd5, 4'd5, 2000, ok);
    chk("k3_done_seen", 64'(ok), 64'd1);
    chk("k3_macs", 64'(macs), 64'd324);
    chk("k3_outs", 64'(outs), 64'd18);
    chk("k3_x_cover", 64'(xs), 64'h15);
    chk("k3_y_cover", 64'(ys), 64'h15);
    chk("k3_model", 64'(mon_err), 64'd0);

    // Handshake: weight arrives three FETCH cycles ahead of activation
    @(posedge clk) #1;
    cfg_kernel = 2'd0; cfg_stride = 2'd0; cfg_w = 4'd1; cfg_h = 4'd1;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0; start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0; bus.b_valid = 1'b1;
    @(negedge clk);
    chk("hs_b_capture", 64'({bus.b_ready, bus.write_b}), 64'd3);
    @(posedge clk) #1;
    @(negedge clk);
    chk("hs_b_held", 64'({bus.b_ready, bus.write_b, bus.a_ready}), 64'd1);
    @(posedge clk) #1;
    @(posedge clk) #1;
    bus.a_valid = 1'b1;
    @(negedge clk);
    chk("hs_a_capture", 64'({bus.write_a, bus.mac_valid}), 64'd2);
    @(posedge clk) #1;
    @(negedge clk);
    chk("hs_mac_after_a", 64'({bus.mac_valid, bus.a_ready, bus.b_ready}), 64'd4);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("hs_done_seen", 64'(ok), 64'd1);
    chk("hs_macs", 64'(macs), 64'd4);
    chk("hs_stalls", 64'(stall_cycles), 64'(HS_STALLS));
    chk("hs_model", 64'(mon_err), 64'd0);

    // Illegal configurations
    @(posedge clk) #1;
    cfg_kernel = 2'd3; cfg_w = 4'd2; cfg_h = 4'd2; start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    @(negedge clk);
    chk("bad_kernel_err", 64'({cfg_error, running}), 64'd2);
    @(negedge clk);
    chk("bad_kernel_pulse", 64'({cfg_error, running}), 64'd0);
    @(posedge clk) #1;
    cfg_kernel = 2'd0; cfg_w = 4'd0; start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    @(negedge clk);
    chk("bad_w_err", 64'({cfg_error, running}), 64'd2);

    // Reset during the first MAC of point (2,0) on a 4x2 map
    @(posedge clk) #1;
    cfg_kernel = 2'd0; cfg_stride = 2'd0; cfg_w = 4'd4; cfg_h = 4'd2; start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    n = 0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.mac_valid === 1'b1) begin
        n++;
        if (n == 17) begin ok = 1'b1; break; end
      end
    end
    chk("rst_reached_point", 64'(ok), 64'd1);
    arst_n_in = 1'b0;
    #1;
    chk("rst_outputs_cleared", all_outs(), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    arst_n_in = 1'b1;
    run(2'd0, 2'd0, 4'd2, 4'd2, 200, ok);
    chk("rerun_done_seen", 64'(ok), 64'd1);
    chk("rerun_macs", 64'(macs), 64'd16);
    chk("rerun_outs", 64'(outs), 64'd8);
    chk("rerun_model", 64'(mon_err), 64'd0);

    // 5x5 kernel on a 1x1 map: psum write-back and zero-seed placement
    run(2'd2, 2'd0, 4'd1, 4'd1, 500, ok);
    chk("k5_done_seen", 64'(ok), 64'd1);
    chk("k5_macs", 64'(macs), 64'd100);
    chk("k5_mem_we", 64'(wes), 64'd4);
    chk("k5_acc_zero", 64'(zeros), 64'd2);
    chk("k5_outs", 64'(outs), 64'd2);
    chk("k5_model", 64'(mon_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
